// File: rtl/jtdsp16_cache_pkg.sv
// jtdsp16_cache_pkg: shared state encoding for the DSP16 do/redo cache sequencer
package jtdsp16_cache_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, LOOP = 2'd2} state_t;
endpackage

// File: rtl/jtdsp16_cache_ram.sv
// jtdsp16_cache_ram: 2**AW x 16 register file, synchronous write, asynchronous read
module jtdsp16_cache_ram #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [15:0]   din,
  input  logic [AW-1:0] ra,
  output logic [15:0]   dout
);
  logic [15:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[wa] <= din;
  assign dout = mem[ra];
endmodule

// File: rtl/jtdsp16_cache.sv
// jtdsp16_cache: captures a do-block from ROM on its first pass, then replays it
// from the cache for the remaining iterations (or for every iteration on redo).
module jtdsp16_cache
  import jtdsp16_cache_pkg::*;
#(
  parameter int AW = 4,
  parameter int KW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          do_start,
  input  logic [AW-1:0] ni,
  input  logic [KW-1:0] k,
  input  logic [15:0]   rom_dout,
  output logic          cache_sel,
  output logic [15:0]   cache_dout,
  output logic          pc_hold,
  output logic          irq_block,
  output logic          done
);
  state_t        st, st_nx;
  logic [AW-1:0] wr_ptr, wr_nx, rd_ptr, rd_nx, len, len_nx;
  logic [KW-1:0] iter, iter_nx, keff;
  logic          fin;
  assign keff      = (k == '0) ? KW'(1) : k;
  assign cache_sel = st == LOOP;
  assign pc_hold   = st == LOOP;
  assign irq_block = st != IDLE;
  jtdsp16_cache_ram #(.AW(AW)) u_ram (
    .clk  (clk),
    .we   (cen && st == LOAD),
    .wa   (wr_ptr),
    .din  (rom_dout),
    .ra   (rd_ptr),
    .dout (cache_dout)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st     <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len    <= '0;
      iter   <= '0;
      done   <= 1'b0;
    end else begin
      st     <= st_nx;
      wr_ptr <= wr_nx;
      rd_ptr <= rd_nx;
      len    <= len_nx;
      iter   <= iter_nx;
      done   <= fin;
    end
  // iter holds the passes still to be replayed from the cache
  always_comb begin
    st_nx   = st;
    wr_nx   = wr_ptr;
    rd_nx   = rd_ptr;
    len_nx  = len;
    iter_nx = iter;
    fin     = 1'b0;
    if (cen)
      case (st)
        IDLE:
          if (do_start) begin
            if (ni != '0) begin
              len_nx  = ni;
              wr_nx   = '0;
              iter_nx = keff - 1'b1;
              st_nx   = LOAD;
            end else if (len != '0) begin
              rd_nx   = '0;
              iter_nx = keff;
              st_nx   = LOOP;
            end else fin = 1'b1;
          end
        LOAD: begin
          wr_nx = wr_ptr + 1'b1;
          if (wr_ptr == len - 1'b1) begin
            if (iter == '0) begin
              st_nx = IDLE;
              fin   = 1'b1;
            end else begin
              rd_nx = '0;
              st_nx = LOOP;
            end
          end
        end
        LOOP: begin
          rd_nx = rd_ptr + 1'b1;
          if (rd_ptr == len - 1'b1) begin
            rd_nx   = '0;
            iter_nx = iter - 1'b1;
            if (iter == KW'(1)) begin
              st_nx = IDLE;
              fin   = 1'b1;
            end
          end
        end
        default: st_nx = IDLE;
      endcase
  end
endmodule

// File: tb/tb_jtdsp16_cache.sv
// tb_jtdsp16_cache: directed do/redo sequences with hand-computed slot expectations
module tb_jtdsp16_cache;
  logic        clk = 1'b0, rst = 1'b1, cen = 1'b1, do_start = 1'b0;
  logic [3:0]  ni = '0;
  logic [6:0]  k = '0;
  logic [15:0] rom_dout = '0, cache_dout;
  logic        cache_sel, pc_hold, irq_block, done;
  int          checks = 0, errors = 0;

  jtdsp16_cache dut (
    .clk(clk), .rst(rst), .cen(cen), .do_start(do_start), .ni(ni), .k(k),
    .rom_dout(rom_dout), .cache_sel(cache_sel), .cache_dout(cache_dout),
    .pc_hold(pc_hold), .irq_block(irq_block), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_sel"}, {15'd0, cache_sel}, 16'd0);
    chk({tag, "_hold"}, {15'd0, pc_hold}, 16'd0);
    chk({tag, "_irq"}, {15'd0, irq_block}, 16'd0);
  endtask

  task automatic start(input logic [3:0] n, input logic [6:0] kk);
    do_start = 1'b1;
    ni = n;
    k = kk;
    tick;
    do_start = 1'b0;
  endtask

  task automatic slot(input string tag, input logic sel, input logic [15:0] d);
    chk({tag, "_sel"}, {15'd0, cache_sel}, {15'd0, sel});
    chk({tag, "_hold"}, {15'd0, pc_hold}, {15'd0, sel});
    chk({tag, "_irq"}, {15'd0, irq_block}, 16'd1);
    chk({tag, "_done"}, {15'd0, done}, 16'd0);
    if (sel) chk({tag, "_dout"}, cache_dout, d);
    tick;
  endtask

  task automatic fin(input string tag);
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    idle_chk(tag);
    tick;
    chk({tag, "_done_end"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    #2;
    idle_chk("reset");
    chk("reset_done", {15'd0, done}, 16'd0);
    tick;
    rst = 1'b0;
    tick;
    idle_chk("post_reset");

    start(4'd2, 7'd3);
    rom_dout = 16'hA0A0;
    slot("do3_ld0", 1'b0, 16'h0);
    rom_dout = 16'hB1B1;
    slot("do3_ld1", 1'b0, 16'h0);
    rom_dout = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      slot("do3_lpA", 1'b1, 16'hA0A0);
      slot("do3_lpB", 1'b1, 16'hB1B1);
    end
    fin("do3");

    start(4'd0, 7'd2);
    for (int i = 0; i < 2; i++) begin
      rom_dout = 16'($urandom);
      slot("redo2_A", 1'b1, 16'hA0A0);
      rom_dout = 16'($urandom);
      slot("redo2_B", 1'b1, 16'hB1B1);
    end
    fin("redo2");

    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    start(4'd0, 7'd5);
    fin("redo_len0");

    start(4'd15, 7'd1);
    for (int i = 0; i < 15; i++) begin
      rom_dout = 16'h1000 + 16'(i);
      cen = 1'b0;
      tick;
      chk("cen0_irq", {15'd0, irq_block}, 16'd1);
      chk("cen0_sel", {15'd0, cache_sel}, 16'd0);
      chk("cen0_done", {15'd0, done}, 16'd0);
      cen = 1'b1;
      slot("ni15_ld", 1'b0, 16'h0);
    end
    fin("ni15");
    start(4'd0, 7'd1);
    for (int i = 0; i < 15; i++) slot("ni15_redo", 1'b1, 16'h1000 + 16'(i));
    fin("ni15_redo");

    start(4'd1, 7'd0);
    rom_dout = 16'hC3C3;
    slot("k0_ld", 1'b0, 16'h0);
    fin("k0");

    start(4'd1, 7'd127);
    rom_dout = 16'hD4D4;
    slot("k127_ld", 1'b0, 16'h0);
    rom_dout = 16'hFFFF;
    for (int i = 0; i < 126; i++) begin
      do_start = (i == 10);
      ni = 4'd3;
      k = 7'd5;
      slot("k127_lp", 1'b1, 16'hD4D4);
    end
    do_start = 1'b0;
    fin("k127");

    start(4'd2, 7'd3);
    rom_dout = 16'h5A5A;
    slot("rst_ld0", 1'b0, 16'h0);
    rom_dout = 16'h6B6B;
    slot("rst_ld1", 1'b0, 16'h0);
    slot("rst_lp0", 1'b1, 16'h5A5A);
    slot("rst_lp1", 1'b1, 16'h6B6B);
    chk("rst_lp2_sel", {15'd0, cache_sel}, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    idle_chk("rst_async");
    chk("rst_async_done", {15'd0, done}, 16'd0);
    tick;
    rst = 1'b0;
    tick;
    start(4'd0, 7'd3);
    fin("rst_redo_noop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
